// File: rtl/uart_wb_pkg.sv
// Shared constants and types for the UART-to-Wishbone debug bridge.
//   Command bytes:   CMD_WR, CMD_RD
//   Response bytes:  RSP_ACK, RSP_NAK
//   Bus widths:      WB_AW, WB_DW, WB_SW
//   FSM encoding:    state_t (IDLE, ADDR, DATA, BUS, RESP, TX_WAIT)
package uart_wb_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = 4;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    BUS     = 3'd3,
    RESP    = 3'd4,
    TX_WAIT = 3'd5
  } state_t;

  // Shift one received byte into the low end of a 32-bit word (MSB-first framing).
  function automatic logic [31:0] shift_in(input logic [31:0] word, input logic [7:0] b);
    return {word[23:0], b};
  endfunction

endpackage

// File: rtl/uart_wb_master_if.sv
// Single-master Wishbone classic bundle used by the debug bridge.
//   master: drives cyc/stb/we/adr/sel/dat_o, receives dat_i/ack_i
//   slave:  mirror image, for the bus fabric or a bench model
interface uart_wb_master_if
  import uart_wb_pkg::*;
;
  logic             wb_cyc_o;
  logic             wb_stb_o;
  logic             wb_we_o;
  logic [WB_AW-1:0] wb_adr_o;
  logic [WB_SW-1:0] wb_sel_o;
  logic [WB_DW-1:0] wb_dat_o;
  logic [WB_DW-1:0] wb_dat_i;
  logic             wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );

endinterface

// File: rtl/uart_wb_master_uart.sv
// 8N1 UART engine: one receive holding byte and one transmit shifter.
//   clk, reset        system clock, synchronous active-high reset
//   rxd / txd         serial line in / out (txd idles high)
//   rx_data/rx_avail  received byte, held valid until rx_ack
//   rx_ack            consumer takes rx_data this cycle
//   rx_error          one-cycle pulse on a bad stop bit
//   tx_data/tx_wr     byte to send, accepted when tx_busy is low
//   tx_busy           high from the cycle after acceptance until the stop bit ends
module uart_wb_master_uart #(
  parameter int unsigned clk_freq = 100000000,
  parameter int unsigned baud     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  input  logic       rx_ack,
  output logic       rx_error,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_busy
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned DIV   = clk_freq / baud;
  localparam int unsigned HALF  = DIV / 2;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        rx_state;
  logic             rxd_s1, rxd_s2;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_sh;

  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_n;
  logic [8:0]       tx_sh;

  // Receiver: synchronise, find start bit, sample each bit near its centre.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_avail <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      rxd_s1   <= rxd;
      rxd_s2   <= rxd_s1;
      rx_error <= 1'b0;
      if (rx_ack) rx_avail <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rxd_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == CNT_W'(HALF - 1)) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rxd_s2 ? RX_IDLE : RX_DATA;  // glitch rejection
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == CNT_W'(DIV - 1)) begin
            rx_cnt <= '0;
            rx_sh  <= {rxd_s2, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == CNT_W'(DIV - 1)) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            if (rxd_s2) begin
              rx_data  <= rx_sh;
              rx_avail <= 1'b1;
            end else begin
              rx_error <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Transmitter: start bit on acceptance, then 8 data bits LSB first, then stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      txd     <= 1'b1;
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_n    <= '0;
      tx_sh   <= '0;
    end else if (!tx_busy) begin
      if (tx_wr) begin
        tx_busy <= 1'b1;
        txd     <= 1'b0;
        tx_sh   <= {1'b1, tx_data};
        tx_cnt  <= '0;
        tx_n    <= '0;
      end
    end else if (tx_cnt == CNT_W'(DIV - 1)) begin
      tx_cnt <= '0;
      if (tx_n == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        txd   <= tx_sh[0];
        tx_sh <= {1'b0, tx_sh[8:1]};
        tx_n  <= tx_n + 4'd1;
      end
    end else begin
      tx_cnt <= tx_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_wb_master.sv
// UART-to-Wishbone debug bridge: decodes framed read/write commands from the
// serial line, runs one 32-bit Wishbone cycle per command and replies.
//   clk, reset   system clock, synchronous active-high reset
//   uart_rxd     serial command input
//   uart_txd     serial response output
//   wb           Wishbone master port (sel is always 4'hF)
//   busy         high whenever the command FSM is not idle
module uart_wb_master
  import uart_wb_pkg::*;
#(
  parameter int unsigned clk_freq    = 100000000,
  parameter int unsigned baud        = 115200,
  parameter int unsigned bus_timeout = 1023,
  parameter int unsigned rx_timeout  = 2000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rxd,
  output logic              uart_txd,
  uart_wb_master_if.master  wb,
  output logic              busy
);

  localparam int unsigned CNT_W = 32;

  state_t           state;
  logic             is_wr;
  logic [1:0]       byte_cnt;
  logic [1:0]       resp_left;
  logic [WB_AW-1:0] adr_q;
  logic [WB_DW-1:0] dat_q;
  logic [31:0]      resp_q;
  logic [CNT_W-1:0] bus_cnt;
  logic [CNT_W-1:0] idle_cnt;
  logic             rx_armed;

  logic [7:0]       rx_data;
  logic             rx_avail;
  logic             rx_ack_c;
  logic             rx_error_unused;
  logic [7:0]       tx_data;
  logic             tx_wr;
  logic             tx_busy;

  uart_wb_master_uart #(
    .clk_freq (clk_freq),
    .baud     (baud)
  ) uart0 (
    .clk      (clk),
    .reset    (reset),
    .rxd      (uart_rxd),
    .txd      (uart_txd),
    .rx_data  (rx_data),
    .rx_avail (rx_avail),
    .rx_ack   (rx_ack_c),
    .rx_error (rx_error_unused),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_busy  (tx_busy)
  );

  // Bytes are only taken while collecting a command; during BUS/RESP they stay pending.
  assign rx_ack_c = rx_avail && rx_armed &&
                    ((state == IDLE) || (state == ADDR) || (state == DATA));

  assign wb.wb_sel_o = 4'hF;

  // Command FSM with registered bus, response and busy outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      is_wr       <= 1'b0;
      byte_cnt    <= '0;
      resp_left   <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      resp_q      <= '0;
      bus_cnt     <= '0;
      idle_cnt    <= '0;
      rx_armed    <= 1'b0;
      tx_data     <= '0;
      tx_wr       <= 1'b0;
      wb.wb_cyc_o <= 1'b0;
      wb.wb_stb_o <= 1'b0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_adr_o <= '0;
      wb.wb_dat_o <= '0;
    end else begin
      tx_wr <= 1'b0;

      // One byte per rx_avail assertion: re-arm only after the engine drops it.
      if (rx_ack_c)       rx_armed <= 1'b0;
      else if (!rx_avail) rx_armed <= 1'b1;

      case (state)
        IDLE: begin
          if (rx_ack_c && ((rx_data == CMD_WR) || (rx_data == CMD_RD))) begin
            state    <= ADDR;
            busy     <= 1'b1;
            is_wr    <= (rx_data == CMD_WR);
            byte_cnt <= '0;
            idle_cnt <= '0;
          end
        end

        ADDR: begin
          if (rx_ack_c) begin
            idle_cnt <= '0;
            adr_q    <= shift_in(adr_q, rx_data);
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (is_wr) begin
                state <= DATA;
              end else begin
                state       <= BUS;
                bus_cnt     <= '0;
                wb.wb_adr_o <= shift_in(adr_q, rx_data);
                wb.wb_we_o  <= 1'b0;
                wb.wb_cyc_o <= 1'b1;
                wb.wb_stb_o <= 1'b1;
              end
            end
          end else if (idle_cnt == CNT_W'(rx_timeout - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (rx_ack_c) begin
            idle_cnt <= '0;
            dat_q    <= shift_in(dat_q, rx_data);
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state       <= BUS;
              bus_cnt     <= '0;
              wb.wb_adr_o <= adr_q;
              wb.wb_dat_o <= shift_in(dat_q, rx_data);
              wb.wb_we_o  <= 1'b1;
              wb.wb_cyc_o <= 1'b1;
              wb.wb_stb_o <= 1'b1;
            end
          end else if (idle_cnt == CNT_W'(rx_timeout - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end
        end

        // Ack is checked first so an ack on the final timeout cycle still succeeds.
        BUS: begin
          if (wb.wb_ack_i) begin
            state       <= RESP;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            resp_q      <= is_wr ? {RSP_ACK, 24'h0} : wb.wb_dat_i;
            resp_left   <= is_wr ? 2'd0 : 2'd3;
          end else if (bus_cnt == CNT_W'(bus_timeout - 1)) begin
            state       <= RESP;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            resp_q      <= {RSP_NAK, 24'h0};
            resp_left   <= 2'd0;
          end else begin
            bus_cnt <= bus_cnt + CNT_W'(1);
          end
        end

        RESP: begin
          if (!tx_busy) begin
            state   <= TX_WAIT;
            tx_wr   <= 1'b1;
            tx_data <= resp_q[31:24];
            resp_q  <= resp_q << 8;
          end
        end

        // tx_busy is stale on the tx_wr cycle; skip one cycle before re-testing it.
        TX_WAIT: begin
          if (resp_left == 2'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state     <= RESP;
            resp_left <= resp_left - 2'd1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_master.sv
// Bench for uart_wb_master: serial command driver, serial response monitor,
// Wishbone slave model with programmable ack delay, and a command-level
// reference model of the expected bus cycle and reply bytes.
module tb_uart_wb_master;

  localparam int unsigned BIT_CYC = 10;    // 100 MHz / 10 Mbaud
  localparam int unsigned BUS_TO  = 15;
  localparam int unsigned RX_TO   = 5000;
  localparam int          NEVER   = 100000;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_rxd = 1'b1;
  logic        uart_txd;
  logic        busy;
  logic        slave_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] slave_rdata = '0;
  int          ack_delay = 0;

  int          tests = 0;
  int          fails = 0;

  logic [7:0]  tx_q[$];
  txn_t        txn_q[$];
  int          len_q[$];

  uart_wb_master_if wb();

  assign wb.wb_ack_i = slave_ack | stray_ack;
  assign wb.wb_dat_i = slave_rdata;

  uart_wb_master #(
    .clk_freq    (100000000),
    .baud        (10000000),
    .bus_timeout (BUS_TO),
    .rx_timeout  (RX_TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd),
    .wb       (wb.master),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Wishbone slave: ack `ack_delay` cycles after stb rises, log each cycle.
  int   wcnt = 0;
  int   cyc_len = 0;
  logic cyc_d = 1'b0;
  always @(negedge clk) begin
    if (wb.wb_cyc_o && !cyc_d)
      txn_q.push_back({wb.wb_adr_o, wb.wb_dat_o, wb.wb_we_o, wb.wb_sel_o});
    if (wb.wb_cyc_o) cyc_len++;
    else if (cyc_d) begin
      len_q.push_back(cyc_len);
      cyc_len = 0;
    end
    cyc_d = wb.wb_cyc_o;
    if (slave_ack) begin
      slave_ack = 1'b0;
      wcnt = 0;
    end else if (wb.wb_cyc_o && wb.wb_stb_o) begin
      if (wcnt == ack_delay) slave_ack = 1'b1;
      else wcnt++;
    end else begin
      wcnt = 0;
    end
  end

  // Serial response monitor: decode 8N1 bytes from uart_txd.
  logic [7:0] mon_b;
  always begin
    @(negedge clk);
    if (!reset && uart_txd === 1'b0) begin
      repeat (15) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        mon_b[i] = uart_txd;
        if (i < 7) repeat (BIT_CYC) @(negedge clk);
      end
      repeat (BIT_CYC) @(negedge clk);
      tx_q.push_back(mon_b);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      uart_rxd = fr[i];
      repeat (BIT_CYC) @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  // Reference: one command, its expected bus cycle, reply bytes and duration.
  task automatic run_cmd(input string tag, input bit is_wr, input logic [31:0] adr,
                         input logic [31:0] dat, input int delay, input logic [31:0] rdata);
    logic [7:0] exp_q[$];
    bit         timed_out;
    int         exp_len;
    int         k;
    txn_t       t;
    logic [7:0] got;

    timed_out = (delay >= int'(BUS_TO));
    exp_len   = timed_out ? int'(BUS_TO) : delay + 1;
    if (timed_out)  exp_q.push_back(8'h15);
    else if (is_wr) exp_q.push_back(8'h06);
    else for (int i = 3; i >= 0; i--) exp_q.push_back(rdata[8*i +: 8]);

    ack_delay   = delay;
    slave_rdata = rdata;
    send_byte(is_wr ? 8'h57 : 8'h52);
    send_word(adr);
    if (is_wr) send_word(dat);

    k = 0;
    while (tx_q.size() < exp_q.size() && k < 3000) begin
      @(negedge clk);
      k++;
    end
    wait_cycles(200);
    chk({tag, ".nbytes"}, 32'(tx_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      got = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
      chk({tag, ".byte"}, {24'h0, got}, {24'h0, exp_q[i]});
    end
    tx_q.delete();

    chk({tag, ".ncyc"}, 32'(txn_q.size()), 32'd1);
    if (txn_q.size() > 0) begin
      t = txn_q.pop_front();
      chk({tag, ".adr"}, t.adr, adr);
      chk({tag, ".we"}, {31'h0, t.we}, {31'h0, is_wr});
      chk({tag, ".sel"}, {28'h0, t.sel}, 32'hF);
      if (is_wr) chk({tag, ".dat"}, t.dat, dat);
    end
    txn_q.delete();
    chk({tag, ".len"}, (len_q.size() > 0) ? 32'(len_q.pop_front()) : 32'hFFFF_FFFF, 32'(exp_len));
    len_q.delete();
    chk({tag, ".busy"}, {31'h0, busy}, 32'h0);
    chk({tag, ".adr_hold"}, wb.wb_adr_o, adr);
  endtask

  initial begin
    int k;
    bit rw;
    logic [31:0] ra, rd;

    // Reset values
    wait_cycles(3);
    chk("rst.cyc", {31'h0, wb.wb_cyc_o}, 32'h0);
    chk("rst.stb", {31'h0, wb.wb_stb_o}, 32'h0);
    chk("rst.we", {31'h0, wb.wb_we_o}, 32'h0);
    chk("rst.adr", wb.wb_adr_o, 32'h0);
    chk("rst.dat", wb.wb_dat_o, 32'h0);
    chk("rst.busy", {31'h0, busy}, 32'h0);
    chk("rst.txd", {31'h0, uart_txd}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    wait_cycles(20);

    // Directed write, read, timeout and the ack-on-last-cycle boundary
    run_cmd("wr", 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 2, 32'h0);
    run_cmd("rd", 1'b0, 32'h0000_2000, 32'h0, 1, 32'h1234_5678);
    run_cmd("bus_to", 1'b0, 32'h0000_3000, 32'h0, NEVER, 32'hCAFE_F00D);
    run_cmd("ack_last", 1'b1, 32'h0000_4000, 32'h0BAD_CAFE, int'(BUS_TO) - 1, 32'h0);
    run_cmd("ack_first", 1'b0, 32'h8000_0004, 32'h0, 0, 32'hA5A5_5A5A);

    // Garbage bytes are swallowed without reply or bus cycle
    send_byte(8'hFF);
    send_byte(8'h00);
    wait_cycles(300);
    chk("garbage.busy", {31'h0, busy}, 32'h0);
    chk("garbage.tx", 32'(tx_q.size()), 32'h0);
    chk("garbage.cyc", 32'(txn_q.size()), 32'h0);
    run_cmd("resync", 1'b0, 32'h0000_5000, 32'h0, 3, 32'h0102_0304);

    // Stray ack while idle has no effect
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    wait_cycles(200);
    chk("stray.busy", {31'h0, busy}, 32'h0);
    chk("stray.tx", 32'(tx_q.size()), 32'h0);

    // Inter-byte timeout drops a partial frame
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_cycles(50);
    chk("partial.busy", {31'h0, busy}, 32'h1);
    wait_cycles(6000);
    chk("abort.busy", {31'h0, busy}, 32'h0);
    chk("abort.cyc", 32'(txn_q.size()), 32'h0);
    chk("abort.tx", 32'(tx_q.size()), 32'h0);
    run_cmd("after_abort", 1'b0, 32'h0000_6000, 32'h0, 2, 32'h8765_4321);

    // Randomised commands, ack delays straddling the timeout
    for (int i = 0; i < 6; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = $urandom();
      rd = $urandom();
      run_cmd(rw ? "rnd_wr" : "rnd_rd", rw, ra, rd, int'($urandom_range(0, 16)), $urandom());
    end

    // Reset in the middle of a bus cycle
    ack_delay = NEVER;
    send_byte(8'h52);
    send_word(32'h0000_7000);
    k = 0;
    while (wb.wb_stb_o !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("midrst.stb_seen", {31'h0, wb.wb_stb_o}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst.cyc", {31'h0, wb.wb_cyc_o}, 32'h0);
    chk("midrst.stb", {31'h0, wb.wb_stb_o}, 32'h0);
    chk("midrst.we", {31'h0, wb.wb_we_o}, 32'h0);
    chk("midrst.busy", {31'h0, busy}, 32'h0);
    chk("midrst.txd", {31'h0, uart_txd}, 32'h1);
    wait_cycles(300);
    chk("midrst.tx", 32'(tx_q.size()), 32'h0);
    txn_q.delete();
    len_q.delete();
    tx_q.delete();
    run_cmd("post_rst", 1'b1, 32'h0000_8008, 32'h1357_9BDF, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
